sobel_stream: RTL
=================

Name: sobel_stream

Overview:
Streaming Sobel edge detector for raster-order pixel streams. It owns its two line buffers and its 3x3 window, so the producer sends one pixel per accepted beat with no external windowing. Computation is a fixed 3-stage pipeline with a selectable magnitude mode and a parametrised pixel width and line length. It sits between the pixel source (camera or frame reader) and the edge-map sink.

Parameters:
PIX_W, 8, pixel bit width for input and output
IMG_W, 640, pixels per line; line buffer depth; must be >= 3
MAG_MODE, 0, 0 = |gx|+|gy|; 1 = max(|gx|,|gy|)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_pix is valid this cycle; no backpressure
in_sof  input  1  qualified by in_valid; marks pixel (0,0) of a frame
in_pix  input  PIX_W  input pixel, unsigned
out_valid  output  1  out_pix is valid this cycle
out_sof  output  1  qualified by out_valid; output for input pixel (0,0)
out_pix  output  PIX_W  edge magnitude, unsigned, saturated

Behaviour:
- Reset: all outputs go to 0. Column counter, row flag and pipeline valid bits are cleared. Line-buffer and window contents are not cleared; masking makes them don't-care. Reset during a frame drops all in-flight results.
- Counters: col runs from 0 to IMG_W-1 and wraps to 0. On wrap, row_ge2 is set once two full lines have been seen.
  - in_valid && in_sof forces col=0 and row count=0 for that pixel.
  - A mid-frame sof restarts counting immediately. Results already in the pipeline still emit.
- Line buffers: two IMG_W-deep buffers and the window shift only when in_valid=1. Gaps in in_valid are allowed at any rate.
- Window: the newest accepted pixel at (r,c) is p8. p0..p8 are row-major, covering rows r-2..r and columns c-2..c. The window centre is (r-1,c-1).
- Gradients, signed, width PIX_W+3:
  - gx = (p2-p0) + 2(p5-p3) + (p8-p6)
  - gy = (p0-p6) + 2(p1-p7) + (p2-p8)
  - All operands are zero-extended before subtraction. No intermediate overflow is permitted.
- Magnitude: take the absolute value of gx and of gy, then combine per MAG_MODE. Results above 2^PIX_W-1 saturate to all-ones.
- Masking: if r<2 or c<2, out_pix=0; out_valid is still asserted.
- Pipeline stages:
  - S1: window register.
  - S2: gx/gy register.
  - S3: abs, combine and clamp, output register.
- Latency and rate:
  - out_valid is asserted exactly 3 cycles after each accepted input, regardless of later gaps.
  - There is exactly one output per accepted input, so output count equals input count.
  - The pipeline never stalls; valid bits shift every cycle.
- out_sof is in_sof delayed 3 cycles with in_valid.

Optional Feature:
SOBEL_THRESH_EN
- Defined: adds port thresh, input, PIX_W bits. After the clamp stage, out_pix = all-ones if magnitude >= thresh, else 0. thresh is sampled in S3. Latency is unchanged, and masked pixels are still 0.
- Undefined: the port does not exist and out_pix is the clamped magnitude.

Test Plan:
1. IMG_W=8, PIX_W=8. Rst 2 cycles, then a 6x8 frame of constant 100 with in_sof on the first pixel -> 48 outputs, all 0; out_sof on the first output, 3 cycles after the first input.
2. Vertical edge: cols 0-3 = 0, cols 4-7 = 255. Then a ramp in_pix = 10*col -> for the edge frame, outputs with window centre col 3 or 4 and r>=2 are 255 (raw 1020 clamped); all others 0. For the ramp frame, interior outputs are 80 and border outputs 0.
3. Diagonal ramp in_pix = 10*(row+col), |gx|=|gy|=80 -> MAG_MODE=0 gives 160 interior; MAG_MODE=1 gives 80.
4. Random in_valid duty of 30% over a full frame -> every output arrives exactly 3 cycles after its input; counts match; values match the gap-free run.
5. Assert rst mid-line 2 cycles after an input, then resume with in_sof -> no out_valid for pre-reset pixels; the new frame treats its first two lines as masked.
6. SOBEL_THRESH_EN, thresh=81, ramp from scenario 2 -> interior outputs 0. With thresh=80 -> interior outputs 255.

Source files
------------

// File: rtl/sobel_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sobel_stream
// Purpose  : Streaming 3x3 Sobel edge detector with internal line buffers and
//            a fixed 3-stage pipeline. Optional macro: SOBEL_THRESH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_stream #(
  parameter int PIX_W    = 8,
  parameter int IMG_W    = 640,
  parameter int MAG_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
`ifdef SOBEL_THRESH_EN
  input  logic [PIX_W-1:0] thresh,
`endif
  output logic             out_valid,
  output logic             out_sof,
  output logic [PIX_W-1:0] out_pix
);

  localparam int CW = $clog2(IMG_W);
  localparam int GW = PIX_W + 3;

  logic [CW-1:0]    col_q, col_d, col_eff;
  logic [1:0]       row_q, row_d, row_eff;   // saturates at 2, meaning "row >= 2"
  logic             mask_in;
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] lb2_q [IMG_W];
  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic [PIX_W-1:0] win_q [9];
  logic             v1_q, sof1_q, mask1_q;
  logic             v2_q, sof2_q, mask2_q;
  logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
  logic [GW-1:0]    ax, ay, mag;
  logic [PIX_W-1:0] clamped, result;
  logic             out_valid_q, out_sof_q;
  logic [PIX_W-1:0] out_pix_q;

  always_comb begin
    col_eff = in_sof ? '0 : col_q;
    row_eff = in_sof ? 2'd0 : row_q;
    mask_in = (row_eff < 2'd2) || (col_eff < CW'(2));
    col_d   = col_q;
    row_d   = row_q;
    if (in_valid) begin
      if (col_eff == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= 2'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign lb1_rd = lb1_q[col_eff];
  assign lb2_rd = lb2_q[col_eff];

  // Line buffers and window hold only data; masking makes their reset state irrelevant.
  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      lb1_q[col_eff] <= in_pix;
      lb2_q[col_eff] <= lb1_rd;
      win_q[0] <= win_q[1];
      win_q[1] <= win_q[2];
      win_q[2] <= lb2_rd;
      win_q[3] <= win_q[4];
      win_q[4] <= win_q[5];
      win_q[5] <= lb1_rd;
      win_q[6] <= win_q[7];
      win_q[7] <= win_q[8];
      win_q[8] <= in_pix;
    end
  end

  function automatic logic signed [GW-1:0] zx(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  always_comb begin
    gx_d = (zx(win_q[2]) - zx(win_q[0])) + ((zx(win_q[5]) - zx(win_q[3])) <<< 1)
         + (zx(win_q[8]) - zx(win_q[6]));
    gy_d = (zx(win_q[0]) - zx(win_q[6])) + ((zx(win_q[1]) - zx(win_q[7])) <<< 1)
         + (zx(win_q[2]) - zx(win_q[8]));
  end

  always_ff @(posedge clk) begin
    gx_q <= gx_d;
    gy_q <= gy_d;
  end

  always_comb begin
    ax      = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    ay      = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag     = (MAG_MODE == 1) ? ((ax > ay) ? ax : ay) : (ax + ay);
    clamped = (mag[GW-1:PIX_W] != '0) ? '1 : mag[PIX_W-1:0];
`ifdef SOBEL_THRESH_EN
    result  = (clamped >= thresh) ? '1 : '0;
`else
    result  = clamped;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      sof1_q      <= 1'b0;
      mask1_q     <= 1'b1;
      v2_q        <= 1'b0;
      sof2_q      <= 1'b0;
      mask2_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_pix_q   <= '0;
    end else begin
      v1_q        <= in_valid;
      sof1_q      <= in_valid && in_sof;
      mask1_q     <= mask_in;
      v2_q        <= v1_q;
      sof2_q      <= sof1_q;
      mask2_q     <= mask1_q;
      out_valid_q <= v2_q;
      out_sof_q   <= sof2_q;
      out_pix_q   <= (v2_q && !mask2_q) ? result : '0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_pix   = out_pix_q;

endmodule
`default_nettype wire
